// File: rtl/sig_detect_ctrl_if.sv
// Bundle of the signal-detect controller's control/status signals between the RX front end and link status.
// Carries o_loss_cnt only when SIG_DETECT_CTRL_LOSS_CNT_EN is defined.
interface sig_detect_ctrl_if;
  logic       i_en;
  logic       i_raw_sd;
  logic       i_train_done;
  logic       o_sd_filt;
  logic       o_train_req;
  logic       o_link_up;
  logic       o_fault;
  logic [3:0] o_retry_cnt;
  logic [2:0] o_state;
`ifdef SIG_DETECT_CTRL_LOSS_CNT_EN
  logic [7:0] o_loss_cnt;

  modport master (
    output i_en, i_raw_sd, i_train_done,
    input  o_sd_filt, o_train_req, o_link_up, o_fault, o_retry_cnt, o_state, o_loss_cnt
  );
  modport slave (
    input  i_en, i_raw_sd, i_train_done,
    output o_sd_filt, o_train_req, o_link_up, o_fault, o_retry_cnt, o_state, o_loss_cnt
  );
`else
  modport master (
    output i_en, i_raw_sd, i_train_done,
    input  o_sd_filt, o_train_req, o_link_up, o_fault, o_retry_cnt, o_state
  );
  modport slave (
    input  i_en, i_raw_sd, i_train_done,
    output o_sd_filt, o_train_req, o_link_up, o_fault, o_retry_cnt, o_state
  );
`endif
endinterface

// File: rtl/sig_detect_ctrl.sv
// LVDS RX link bring-up: hysteresis filter on signal detect, settle/train/up sequencing with bounded retries.
// Optional macro SIG_DETECT_CTRL_LOSS_CNT_EN adds a saturating UP->QUALIFY loss counter.
module sig_detect_ctrl #(
  parameter int FILTER_WIDTH   = 8,
  parameter int SETTLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int RETRY_MAX      = 3
) (
  input logic             i_clk,
  input logic             i_arst,
  sig_detect_ctrl_if.slave bus
);

  localparam int TMAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] SETTLE_LAST  = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    RETRY_LIM    = 4'(RETRY_MAX);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_QUALIFY = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_TRAIN   = 3'd3,
    ST_UP      = 3'd4,
    ST_FAULT   = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [FILTER_WIDTH-1:0] sr_q, sr_d;
  logic                    sd_filt_q, sd_filt_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [3:0]              retry_q, retry_d;
  logic [3:0]              retry_inc_s;
  logic                    train_req_q, train_req_d;
  logic                    link_up_q, link_up_d;
  logic                    fault_q, fault_d;

  // Filter, sequencing and output decode; outputs are decoded from the next state so they align with o_state.
  always_comb begin
    sr_d = {sr_q[FILTER_WIDTH-2:0], bus.i_raw_sd};
    if (&sr_q) begin
      sd_filt_d = 1'b1;
    end else if (~|sr_q) begin
      sd_filt_d = 1'b0;
    end else begin
      sd_filt_d = sd_filt_q;
    end

    retry_inc_s = (retry_q == 4'd15) ? 4'd15 : retry_q + 4'd1;
    state_d     = state_q;
    retry_d     = retry_q;

    if (!bus.i_en) begin
      state_d = ST_IDLE;
      retry_d = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_QUALIFY;
          retry_d = 4'd0;
        end
        ST_QUALIFY: begin
          if (sd_filt_q) state_d = ST_SETTLE;
          else           state_d = ST_QUALIFY;
        end
        ST_SETTLE: begin
          if (!sd_filt_q)                  state_d = ST_QUALIFY;
          else if (timer_q == SETTLE_LAST) state_d = ST_TRAIN;
          else                             state_d = ST_SETTLE;
        end
        ST_TRAIN: begin
          // Done outranks a coincident timeout.
          if (!sd_filt_q) begin
            state_d = ST_QUALIFY;
          end else if (bus.i_train_done) begin
            state_d = ST_UP;
            retry_d = 4'd0;
          end else if (timer_q == TIMEOUT_LAST) begin
            retry_d = retry_inc_s;
            state_d = (retry_inc_s == RETRY_LIM) ? ST_FAULT : ST_SETTLE;
          end else begin
            state_d = ST_TRAIN;
          end
        end
        ST_UP: begin
          if (!sd_filt_q) begin
            state_d = ST_QUALIFY;
            retry_d = 4'd0;
          end else begin
            state_d = ST_UP;
          end
        end
        ST_FAULT: state_d = ST_FAULT;
        default: begin
          state_d = ST_IDLE;
          retry_d = 4'd0;
        end
      endcase
    end

    if (state_d != state_q) timer_d = {TW{1'b0}};
    else                    timer_d = timer_q + TW'(1);

    train_req_d = (state_d == ST_TRAIN);
    link_up_d   = (state_d == ST_UP);
    fault_d     = (state_d == ST_FAULT);
  end

  // Controller state registers.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q     <= ST_IDLE;
      sr_q        <= {FILTER_WIDTH{1'b0}};
      sd_filt_q   <= 1'b0;
      timer_q     <= {TW{1'b0}};
      retry_q     <= 4'd0;
      train_req_q <= 1'b0;
      link_up_q   <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      sd_filt_q   <= sd_filt_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      train_req_q <= train_req_d;
      link_up_q   <= link_up_d;
      fault_q     <= fault_d;
    end
  end

  assign bus.o_sd_filt   = sd_filt_q;
  assign bus.o_train_req = train_req_q;
  assign bus.o_link_up   = link_up_q;
  assign bus.o_fault     = fault_q;
  assign bus.o_retry_cnt = retry_q;
  assign bus.o_state     = state_q;

`ifdef SIG_DETECT_CTRL_LOSS_CNT_EN
  logic [7:0] loss_q, loss_d;

  // Count link drops; survives i_en low, only i_arst clears it.
  always_comb begin
    if ((state_q == ST_UP) && (state_d == ST_QUALIFY) && (loss_q != 8'hFF)) begin
      loss_d = loss_q + 8'd1;
    end else begin
      loss_d = loss_q;
    end
  end

  // Loss counter register.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) loss_q <= 8'd0;
    else        loss_q <= loss_d;
  end

  assign bus.o_loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_sig_detect_ctrl.sv
// Scoreboard bench for sig_detect_ctrl: stimulus queues expected state/filter changes and snapshots,
// a negedge monitor pops and compares them against the DUT.
module tb_sig_detect_ctrl;

  typedef struct {
    string      name;
    logic [2:0] st;
    logic       sd;
    logic       trq;
    logic       lup;
    logic       flt;
    logic [3:0] rc;
    logic [7:0] loss;
    int         cyc;
  } exp_t;

  typedef struct {
    string name;
    logic  val;
    int    cyc;
  } filt_t;

  logic clk;
  logic arst;
  int   cyc;
  int   tests;
  int   failures;

  exp_t  chg_q[$];
  exp_t  snap_q[$];
  filt_t filt_q[$];

  sig_detect_ctrl_if bus ();

  sig_detect_ctrl #(
    .FILTER_WIDTH  (4),
    .SETTLE_CYCLES (16),
    .TIMEOUT_CYCLES(32),
    .RETRY_MAX     (2)
  ) dut (
    .i_clk (clk),
    .i_arst(arst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_chg(input string n, input logic [2:0] st, input logic sd, input logic trq,
                          input logic lup, input logic flt, input logic [3:0] rc, input int c);
    exp_t e;
    e.name = n; e.st = st; e.sd = sd; e.trq = trq; e.lup = lup; e.flt = flt;
    e.rc = rc; e.loss = 8'd0; e.cyc = c;
    chg_q.push_back(e);
  endtask

  task automatic push_snap(input string n, input logic [2:0] st, input logic sd, input logic [7:0] loss);
    exp_t e;
    e.name = n; e.st = st; e.sd = sd; e.trq = 1'b0; e.lup = 1'b0; e.flt = 1'b0;
    e.rc = 4'd0; e.loss = loss; e.cyc = -1;
    snap_q.push_back(e);
  endtask

  task automatic push_filt(input string n, input logic v, input int c);
    filt_t f;
    f.name = n; f.val = v; f.cyc = c;
    filt_q.push_back(f);
  endtask

  task automatic check_rec(input exp_t e, input bit with_loss);
    logic ok;
    logic [7:0] loss_act;
    loss_act = 8'd0;
`ifdef SIG_DETECT_CTRL_LOSS_CNT_EN
    loss_act = bus.o_loss_cnt;
`endif
    tests++;
    ok = (bus.o_state === e.st) && (bus.o_sd_filt === e.sd) && (bus.o_train_req === e.trq) &&
         (bus.o_link_up === e.lup) && (bus.o_fault === e.flt) && (bus.o_retry_cnt === e.rc) &&
         ((e.cyc < 0) || (cyc == e.cyc));
`ifdef SIG_DETECT_CTRL_LOSS_CNT_EN
    if (with_loss && (loss_act !== e.loss)) ok = 1'b0;
`endif
    if (!ok) begin
      failures++;
      $display("FAIL %s: got st=%0d sd=%0b trq=%0b lup=%0b flt=%0b rc=%0d loss=%0d cyc=%0d, expected st=%0d sd=%0b trq=%0b lup=%0b flt=%0b rc=%0d loss=%0d cyc=%0d",
               e.name, bus.o_state, bus.o_sd_filt, bus.o_train_req, bus.o_link_up, bus.o_fault,
               bus.o_retry_cnt, loss_act, cyc, e.st, e.sd, e.trq, e.lup, e.flt, e.rc,
               with_loss ? e.loss : loss_act, e.cyc);
    end
  endtask

  // Monitor: compares on every observed state/filter change and on queued snapshots.
  initial begin
    logic [2:0] prev_st;
    logic       prev_sd;
    exp_t       e;
    filt_t      f;
    prev_st = 3'd0;
    prev_sd = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.o_state !== prev_st) begin
        if (chg_q.size() == 0) begin
          tests++; failures++;
          $display("FAIL unexpected_state_change: got st=%0d at cyc=%0d, expected no change", bus.o_state, cyc);
        end else begin
          e = chg_q.pop_front();
          check_rec(e, 1'b0);
        end
        prev_st = bus.o_state;
      end
      if (bus.o_sd_filt !== prev_sd) begin
        tests++;
        if (filt_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_filt_change: got sd=%0b at cyc=%0d, expected no change", bus.o_sd_filt, cyc);
        end else begin
          f = filt_q.pop_front();
          if ((bus.o_sd_filt !== f.val) || (cyc != f.cyc)) begin
            failures++;
            $display("FAIL %s: got sd=%0b cyc=%0d, expected sd=%0b cyc=%0d", f.name, bus.o_sd_filt, cyc, f.val, f.cyc);
          end
        end
        prev_sd = bus.o_sd_filt;
      end
      if (snap_q.size() != 0) begin
        e = snap_q.pop_front();
        check_rec(e, 1'b1);
      end
    end
  end

  task automatic at_edge(input int c);
    if (cyc > c) begin
      tests++; failures++;
      $display("FAIL schedule: got cyc=%0d, expected at most %0d", cyc, c);
    end
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Stimulus: cycle numbers are absolute posedge indices, expectations derived by hand.
  initial begin
    arst = 1'b1;
    bus.i_en = 1'b0;
    bus.i_raw_sd = 1'b0;
    bus.i_train_done = 1'b0;
    tests = 0;
    failures = 0;

    at_edge(2);
    push_snap("reset_state", 3'd0, 1'b0, 8'd0);
    arst = 1'b0;

    // Short 3-cycle glitch must not flip the filter; a stable rise shows 5 clocks later.
    at_edge(4);  bus.i_raw_sd = 1'b1;
    at_edge(7);  bus.i_raw_sd = 1'b0;
    at_edge(12); push_snap("glitch_ignored", 3'd0, 1'b0, 8'd0);
    at_edge(14); bus.i_raw_sd = 1'b1; push_filt("filt_rise", 1'b1, 19);

    // Normal bring-up with done 10 cycles into TRAIN.
    at_edge(22);
    bus.i_en = 1'b1;
    push_chg("bringup_qualify", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 23);
    push_chg("bringup_settle",  3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 24);
    push_chg("bringup_train",   3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 40);
    push_chg("bringup_up",      3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 51);
    at_edge(50); bus.i_train_done = 1'b1;
    at_edge(51); bus.i_train_done = 1'b0;

    // Loss of signal while UP.
    at_edge(55);
    bus.i_raw_sd = 1'b0;
    push_filt("filt_fall", 1'b0, 60);
    push_chg("los_qualify", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 61);
    at_edge(63); push_snap("loss_count", 3'd1, 1'b0, 8'd1);

    // Two timeouts with RETRY_MAX=2 end in FAULT; dropping enable clears it.
    at_edge(65);
    bus.i_raw_sd = 1'b1;
    push_filt("filt_rise2", 1'b1, 70);
    push_chg("retry_settle0", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 71);
    push_chg("retry_train0",  3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 87);
    push_chg("retry_settle1", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 119);
    push_chg("retry_train1",  3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 135);
    push_chg("retry_fault",   3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 167);
    at_edge(170);
    bus.i_en = 1'b0;
    push_chg("fault_clear_idle", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 171);

    // Done coincident with the timeout cycle wins.
    at_edge(174);
    bus.i_en = 1'b1;
    push_chg("race_qualify", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 175);
    push_chg("race_settle",  3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 176);
    push_chg("race_train",   3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 192);
    push_chg("race_up",      3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 224);
    at_edge(223); bus.i_train_done = 1'b1;
    at_edge(224); bus.i_train_done = 1'b0;

    // Async reset in TRAIN, then restart.
    at_edge(227);
    bus.i_en = 1'b0;
    push_chg("reidle", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 228);
    at_edge(230);
    bus.i_en = 1'b1;
    push_chg("re_qualify", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 231);
    push_chg("re_settle",  3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 232);
    push_chg("re_train",   3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 248);
    at_edge(255);
    push_chg("arst_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 255);
    push_filt("arst_filt", 1'b0, 255);
    arst = 1'b1;
    at_edge(257);
    arst = 1'b0;
    push_chg("post_arst_qualify", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 258);
    push_filt("post_arst_filt", 1'b1, 262);
    push_chg("post_arst_settle", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 263);
    at_edge(265); push_snap("post_arst_loss", 3'd2, 1'b1, 8'd0);

    at_edge(270);
    tests++;
    if ((chg_q.size() != 0) || (filt_q.size() != 0) || (snap_q.size() != 0)) begin
      failures++;
      $display("FAIL drain: got pending chg=%0d filt=%0d snap=%0d, expected all 0",
               chg_q.size(), filt_q.size(), snap_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
